// File: rtl/sfu_array_if.sv
// Handshake and data bundle between the PE array bottom row and the sfu_array block.
// SFU_ARRAY_SAT_EN adds the per-lane sticky saturation flag to the bundle.
interface sfu_array_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int cnt_bw  = 4
);
    logic                     start;
    logic [cnt_bw-1:0]        num_pass;
    logic                     relu_en;
    logic                     in_valid;
    logic                     in_ready;
    logic [col*psum_bw-1:0]   psum_in;
    logic                     out_valid;
    logic                     out_ready;
    logic [col*psum_bw-1:0]   psum_out;
    logic                     busy;
`ifdef SFU_ARRAY_SAT_EN
    logic [col-1:0]           sat_flag;

    modport master (
        output start, num_pass, relu_en, in_valid, psum_in, out_ready,
        input  in_ready, out_valid, psum_out, busy, sat_flag
    );
    modport slave (
        input  start, num_pass, relu_en, in_valid, psum_in, out_ready,
        output in_ready, out_valid, psum_out, busy, sat_flag
    );
`else
    modport master (
        output start, num_pass, relu_en, in_valid, psum_in, out_ready,
        input  in_ready, out_valid, psum_out, busy
    );
    modport slave (
        input  start, num_pass, relu_en, in_valid, psum_in, out_ready,
        output in_ready, out_valid, psum_out, busy
    );
`endif
endinterface

// File: rtl/sfu_array.sv
// Multi-lane psum accumulator with optional ReLU and valid/ready in/out handshakes.
// Define SFU_ARRAY_SAT_EN for saturating adds and the sticky per-lane sat_flag output.
module sfu_array #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int cnt_bw  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    sfu_array_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACC, POST, OUT} state_t;

    state_t                    state_reg, state_next;
    logic [cnt_bw-1:0]         num_pass_reg;
    logic [cnt_bw-1:0]         pass_cnt_reg;
    logic [cnt_bw-1:0]         pass_cnt_inc;
    logic                      relu_en_reg;
    logic                      start_accept;
    logic                      beat_accept;
    logic                      first_beat;
    logic                      last_beat;
    logic signed [psum_bw-1:0] acc_reg [col];
    logic signed [psum_bw-1:0] out_reg [col];
`ifdef SFU_ARRAY_SAT_EN
    logic                      sat_reg [col];
`endif

    assign start_accept = (state_reg == IDLE) && bus.start;
    assign beat_accept  = (state_reg == ACC) && bus.in_valid;
    assign pass_cnt_inc = pass_cnt_reg + cnt_bw'(1);
    assign first_beat   = (pass_cnt_reg == '0);
    assign last_beat    = beat_accept && (pass_cnt_inc == num_pass_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        case (state_reg)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) state_next = ACC;
            end
            ACC: begin
                bus.in_ready = 1'b1;
                if (last_beat) state_next = POST;
            end
            POST: state_next = OUT;
            OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A requested pass count of zero behaves as a single pass.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_pass_reg <= '0;
            relu_en_reg  <= 1'b0;
            pass_cnt_reg <= '0;
        end else if (start_accept) begin
            num_pass_reg <= (bus.num_pass == '0) ? cnt_bw'(1) : bus.num_pass;
            relu_en_reg  <= bus.relu_en;
            pass_cnt_reg <= '0;
        end else if (beat_accept) begin
            pass_cnt_reg <= pass_cnt_inc;
        end
    end

    for (genvar gi = 0; gi < col; gi++) begin : g_lane
        logic signed [psum_bw-1:0] lane_in;
        logic signed [psum_bw-1:0] lane_sum;
        logic signed [psum_bw-1:0] lane_post;

        assign lane_in = bus.psum_in[gi*psum_bw +: psum_bw];

`ifdef SFU_ARRAY_SAT_EN
        logic [psum_bw:0] sum_wide;
        logic             lane_clamp;

        // One guard bit: overflow iff the guard and sign bits disagree.
        assign sum_wide   = {acc_reg[gi][psum_bw-1], acc_reg[gi]} + {lane_in[psum_bw-1], lane_in};
        assign lane_clamp = sum_wide[psum_bw] ^ sum_wide[psum_bw-1];

        always_comb begin
            lane_sum = sum_wide[psum_bw-1:0];
            if (lane_clamp) begin
                lane_sum = sum_wide[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                             : {1'b0, {(psum_bw-1){1'b1}}};
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sat_reg[gi] <= 1'b0;
            end else if (start_accept) begin
                sat_reg[gi] <= 1'b0;
            end else if (beat_accept && !first_beat && lane_clamp) begin
                sat_reg[gi] <= 1'b1;
            end
        end
`else
        assign lane_sum = acc_reg[gi] + lane_in;
`endif

        assign lane_post = (relu_en_reg && acc_reg[gi][psum_bw-1]) ? '0 : acc_reg[gi];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                acc_reg[gi] <= '0;
            end else if (beat_accept) begin
                acc_reg[gi] <= first_beat ? lane_in : lane_sum;
            end else if (state_reg == POST) begin
                acc_reg[gi] <= lane_post;
            end
        end

        // Separate output register so the next job's loads never disturb the shown result.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                out_reg[gi] <= '0;
            end else if (state_reg == POST) begin
                out_reg[gi] <= lane_post;
            end
        end
    end

    always_comb begin
        bus.psum_out = '0;
        for (int k = 0; k < col; k++) begin
            bus.psum_out[k*psum_bw +: psum_bw] = out_reg[k];
        end
    end

`ifdef SFU_ARRAY_SAT_EN
    always_comb begin
        bus.sat_flag = '0;
        for (int k = 0; k < col; k++) begin
            bus.sat_flag[k] = sat_reg[k];
        end
    end
`endif

endmodule
